// File: rtl/anubis_round_controller.sv
// Anubis round sequencer: LOAD, NUM_ROUNDS rounds, then a DONE pulse.
// Optional masked mode (ANUBIS_MASKED_EN) runs each round once per share.
module anubis_round_controller #(
    parameter int NUM_ROUNDS       = 12,
    parameter int CYCLES_PER_ROUND = 2,
    parameter int NUM_SHARES       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [127:0]          rc_data,
    output logic [3:0]            round_counter,
    output logic [127:0]          rc_q,
    output logic                  load_en,
    output logic                  round_en,
    output logic                  final_round,
    output logic                  busy,
    output logic                  done
`ifdef ANUBIS_MASKED_EN
    ,
    output logic [$clog2(NUM_SHARES)-1:0] share_idx
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PW = $clog2(CYCLES_PER_ROUND);
    localparam logic [PW-1:0] LAST_PH  = PW'(CYCLES_PER_ROUND - 1);
    localparam logic [3:0]    LAST_RND = 4'(NUM_ROUNDS);

`ifdef ANUBIS_MASKED_EN
    localparam int MIN_SHARES = 2;
`else
    localparam int MIN_SHARES = 1;
`endif

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 14 ||
            CYCLES_PER_ROUND < 2 || NUM_SHARES < MIN_SHARES) begin : g_param_err
            $error("anubis_round_controller: illegal parameters");
        end
    endgenerate

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;
    logic [3:0]    cnt_n;
    logic          last_share;
    logic          first_share;

`ifdef ANUBIS_MASKED_EN
    localparam int SW = $clog2(NUM_SHARES);
    localparam logic [SW-1:0] LAST_SH = SW'(NUM_SHARES - 1);
    logic [SW-1:0] share_n;
    assign last_share  = (share_idx == LAST_SH);
    assign first_share = (share_idx == '0);
`else
    assign last_share  = 1'b1;
    assign first_share = 1'b1;
`endif

    // Next-state, round counter, phase and share sequencing
    always_comb begin
        state_n = state;
        cnt_n   = round_counter;
        phase_n = phase;
`ifdef ANUBIS_MASKED_EN
        share_n = share_idx;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = 4'd0;
                if (start && !abort) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                state_n = S_ROUND;
                cnt_n   = 4'd1;
                phase_n = '0;
`ifdef ANUBIS_MASKED_EN
                share_n = '0;
`endif
            end
            S_ROUND: begin
                if (phase == LAST_PH) begin
                    phase_n = '0;
                    if (last_share) begin
`ifdef ANUBIS_MASKED_EN
                        share_n = '0;
`endif
                        if (round_counter == LAST_RND) begin
                            state_n = S_DONE;
                            cnt_n   = 4'd0;
                        end else begin
                            cnt_n = round_counter + 4'd1;
                        end
                    end else begin
`ifdef ANUBIS_MASKED_EN
                        share_n = share_idx + 1'b1;
`endif
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
        // Cancel wins over everything outside IDLE; rc_q is left untouched
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
            phase_n = '0;
`ifdef ANUBIS_MASKED_EN
            share_n = '0;
`endif
        end
    end

    // Register state and derive every output from the next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            phase         <= '0;
            round_counter <= 4'd0;
            rc_q          <= '0;
            load_en       <= 1'b0;
            round_en      <= 1'b0;
            final_round   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef ANUBIS_MASKED_EN
            share_idx     <= '0;
`endif
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            round_counter <= cnt_n;
            load_en       <= (state_n == S_LOAD);
            busy          <= (state_n == S_LOAD) || (state_n == S_ROUND);
            done          <= (state_n == S_DONE);
            round_en      <= (state_n == S_ROUND) && (phase_n == LAST_PH);
            final_round   <= (state_n == S_ROUND) && (cnt_n == LAST_RND);
`ifdef ANUBIS_MASKED_EN
            share_idx     <= share_n;
`endif
            // Counter has been stable for a full cycle by phase 0
            if (state == S_ROUND && phase == '0 && first_share && !abort) begin
                rc_q <= rc_data;
            end
        end
    end

endmodule

// File: tb/tb_anubis_round_controller.sv
// Self-checking bench for anubis_round_controller.
// Expected outputs come from an arithmetic per-cycle schedule of a pass.
module tb_anubis_round_controller;

    localparam int NR  = 12;
    localparam int CPR = 2;
    localparam int NS  = 2;
`ifdef ANUBIS_MASKED_EN
    localparam int NSE = NS;
`else
    localparam int NSE = 1;
`endif
    localparam int L  = CPR * NSE;
    localparam int KD = NR * L + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] rc_data;
    logic [3:0]   round_counter;
    logic [127:0] rc_q;
    logic         load_en;
    logic         round_en;
    logic         final_round;
    logic         busy;
    logic         done;
`ifdef ANUBIS_MASKED_EN
    logic [$clog2(NS)-1:0] share_idx;
`endif

    logic [127:0] rc_table [16];
    logic [127:0] exp_rc;
    int n_assert = 0;
    int n_fail   = 0;

    assign rc_data = rc_table[round_counter];

    always #5 clk = ~clk;

    anubis_round_controller #(
        .NUM_ROUNDS(NR),
        .CYCLES_PER_ROUND(CPR),
        .NUM_SHARES(NS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .rc_data(rc_data),
        .round_counter(round_counter),
        .rc_q(rc_q),
        .load_en(load_en),
        .round_en(round_en),
        .final_round(final_round),
        .busy(busy),
        .done(done)
`ifdef ANUBIS_MASKED_EN
        ,
        .share_idx(share_idx)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_table();
        for (int i = 0; i < 16; i++) begin
            rc_table[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic check_idle();
        chk("idle_load_en", 128'(load_en), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_done", 128'(done), 128'(0));
        chk("idle_round_en", 128'(round_en), 128'(0));
        chk("idle_final", 128'(final_round), 128'(0));
        chk("idle_counter", 128'(round_counter), 128'(0));
        chk("idle_rc_q", rc_q, exp_rc);
`ifdef ANUBIS_MASKED_EN
        chk("idle_share", 128'(share_idx), 128'(0));
`endif
    endtask

    // k = cycles since the LOAD cycle (k=0 is LOAD, k=KD is DONE)
    task automatic check_k(input int k);
        int r, w, sh, ph;
        bit e_load, e_busy, e_done, e_ren, e_fin;
        r = 0; sh = 0; ph = 0;
        e_load = (k == 0);
        e_done = (k == KD);
        e_busy = (k < KD);
        e_ren = 1'b0;
        e_fin = 1'b0;
        if (k > 0 && k < KD) begin
            w  = (k - 1) % L;
            r  = (k - 1) / L + 1;
            sh = w / CPR;
            ph = w % CPR;
            e_ren = (ph == CPR - 1);
            e_fin = (r == NR);
            if (sh > 0 || ph > 0) exp_rc = rc_table[r];
        end
        chk($sformatf("load_en@%0d", k), 128'(load_en), 128'(e_load));
        chk($sformatf("busy@%0d", k), 128'(busy), 128'(e_busy));
        chk($sformatf("done@%0d", k), 128'(done), 128'(e_done));
        chk($sformatf("round_en@%0d", k), 128'(round_en), 128'(e_ren));
        chk($sformatf("final@%0d", k), 128'(final_round), 128'(e_fin));
        chk($sformatf("counter@%0d", k), 128'(round_counter), 128'(r));
        chk($sformatf("rc_q@%0d", k), rc_q, exp_rc);
`ifdef ANUBIS_MASKED_EN
        chk($sformatf("share@%0d", k), 128'(share_idx), 128'(sh));
`endif
    endtask

    // mode 0: full pass, 1: abort at stop_k, 2: async reset at stop_k
    task automatic run_pass(input int mode, input int stop_k,
                            input bit hold, input bit rnd);
        start = 1'b1;
        tick();
        for (int k = 0; k <= KD; k++) begin
            check_k(k);
            if (mode == 1 && k == stop_k) begin
                start = 1'b0;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_idle();
                repeat (3) begin
                    tick();
                    check_idle();
                end
                return;
            end
            if (mode == 2 && k == stop_k) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1 exp_rc = '0;
                check_idle();
                #1 rst_n = 1'b1;
                tick();
                check_idle();
                return;
            end
            if (k == KD) start = hold | rnd;
            else start = hold | (rnd & 1'($urandom));
            tick();
        end
        check_idle();
        start = hold;
    endtask

    initial begin
        fill_table();
        exp_rc = '0;
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle();
        tick();
        tick();
        check_idle();
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check_idle();
        tick();
        check_idle();

        run_pass(0, 0, 1'b0, 1'b0);
        fill_table();
        run_pass(0, 0, 1'b0, 1'b1);

        run_pass(1, 1 + 4 * L + 1, 1'b0, 1'b0);
        run_pass(0, 0, 1'b0, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        check_idle();
        tick();
        check_idle();
        start = 1'b0;
        abort = 1'b0;

        repeat (3) begin
            fill_table();
            run_pass(1, int'($urandom_range(KD, 0)), 1'b0, 1'b1);
        end

        run_pass(0, 0, 1'b1, 1'b0);
        run_pass(0, 0, 1'b1, 1'b0);
        run_pass(0, 0, 1'b0, 1'b0);

        run_pass(2, int'($urandom_range(KD, 1)), 1'b0, 1'b0);
        fill_table();
        run_pass(0, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
